// File: rtl/uart_mem_dump_if.sv
// Word-read port between the dump engine and instruction/data memory; data returns one cycle after rd.
// No backpressure: memory must answer every strobe on the following cycle.
interface uart_mem_dump_if;
    logic        rd;
    logic [14:0] adr;
    logic [31:0] dat;

    modport master (output rd, output adr, input dat);
    modport slave  (input rd, input adr, output dat);
endinterface

// File: rtl/uart_mem_dump.sv
// Streams word_cnt words from memory out of an 8N1 UART, LSB byte first; first start bit 3 cycles after start.
// No backpressure: start requests arriving while busy or in DONE are dropped, never queued.
module uart_mem_dump #(
    parameter int unsigned CLK_DIV = 87
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [14:0]     base_adr_i,
    input  logic [14:0]     word_cnt_i,
    uart_mem_dump_if.master mem,
    output logic            tx_o,
    output logic            busy_o,
    output logic            done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP, DONE} state_t;

    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

    state_t      state_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        rd_q;
    logic [14:0] adr_q;
    logic [14:0] cnt_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_q;
    logic [1:0]  byte_q;
    logic [31:0] word_q;

    logic [14:0] adr_d;
    logic [14:0] cnt_d;
    logic        bit_end;

    assign adr_d   = adr_q + 15'd1;
    assign cnt_d   = cnt_q - 15'd1;
    assign bit_end = (timer_q == 16'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            adr_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (start_i) begin
                        adr_q <= base_adr_i;
                        cnt_q <= word_cnt_i;
                        if (word_cnt_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            rd_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                FETCH: state_q <= CAPTURE;
                CAPTURE: begin
                    word_q  <= mem.dat;
                    byte_q  <= '0;
                    tx_q    <= 1'b0;
                    timer_q <= BIT_RELOAD;
                    state_q <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= word_q[0];
                        bit_q   <= '0;
                        timer_q <= BIT_RELOAD;
                        state_q <= DATA;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                DATA: begin
                    // The word shifts right one bit per data bit, so bytes leave in [7:0]..[31:24] order.
                    if (bit_end) begin
                        word_q  <= word_q >> 1;
                        timer_q <= BIT_RELOAD;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q  <= word_q[1];
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_q != 2'd3) begin
                            byte_q  <= byte_q + 2'd1;
                            tx_q    <= 1'b0;
                            timer_q <= BIT_RELOAD;
                            state_q <= START;
                        end else if (cnt_d != '0) begin
                            cnt_q   <= cnt_d;
                            adr_q   <= adr_d;
                            rd_q    <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.rd  = rd_q;
    assign mem.adr = adr_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench: DUT A (CLK_DIV=4) for exact cycle timing, DUT B (CLK_DIV=87) for randomised dumps.
// Cycle numbers are sampled on the falling edge; ts is the count just after the edge that accepted start.
module tb_uart_mem_dump;
    localparam int DIV_A = 4;
    localparam int DIV_B = 87;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a;
    logic        start_b;
    logic [14:0] base;
    logic [14:0] cnt;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;
    logic        use_b = 1'b0;

    uart_mem_dump_if ifa ();
    uart_mem_dump_if ifb ();

    uart_mem_dump #(.CLK_DIV(DIV_A)) dut_a (
        .clock(clk), .reset(reset), .start_i(start_a), .base_adr_i(base), .word_cnt_i(cnt),
        .mem(ifa), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a));

    uart_mem_dump #(.CLK_DIV(DIV_B)) dut_b (
        .clock(clk), .reset(reset), .start_i(start_b), .base_adr_i(base), .word_cnt_i(cnt),
        .mem(ifb), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b));

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        if (a == 15'h4000) return 32'h1234_5678;
        return {a[7:0] ^ 8'hC3, 1'b1, a[14:8], a[7:0], 8'h5A ^ a[14:7]};
    endfunction

    always @(posedge clk) begin
        ifa.dat <= ifa.rd ? mem_word(ifa.adr) : 32'hDEAD_BEEF;
        ifb.dat <= ifb.rd ? mem_word(ifb.adr) : 32'hDEAD_BEEF;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rd_s, done_s, busy_s, tx_s;
    logic [14:0] adr_s;
    int          div_s;
    assign rd_s   = use_b ? ifb.rd  : ifa.rd;
    assign adr_s  = use_b ? ifb.adr : ifa.adr;
    assign done_s = use_b ? done_b  : done_a;
    assign busy_s = use_b ? busy_b  : busy_a;
    assign tx_s   = use_b ? tx_b    : tx_a;
    assign div_s  = use_b ? DIV_B   : DIV_A;

    int rd_adr[$];
    int rd_cyc[$];
    int done_n    = 0;
    int done_cyc  = 0;
    int busy_cnt  = 0;
    int txlow_cnt = 0;

    always @(negedge clk) begin
        if (rd_s === 1'b1) begin
            rd_adr.push_back(int'(adr_s));
            rd_cyc.push_back(cyc);
        end
        if (done_s === 1'b1) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (busy_s === 1'b1) busy_cnt <= busy_cnt + 1;
        if (tx_s === 1'b0) txlow_cnt <= txlow_cnt + 1;
    end

    // UART receiver: samples mid-bit, logs byte, framing flag and start-bit cycle.
    logic [7:0] rx_b[$];
    bit         rx_ok[$];
    int         rx_t[$];

    initial begin : rx_model
        int         t0;
        logic       sb, sp;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_s === 1'b0) begin
                t0 = cyc;
                repeat (div_s / 2) @(negedge clk);
                sb = tx_s;
                for (int i = 0; i < 8; i++) begin
                    repeat (div_s) @(negedge clk);
                    b[i] = tx_s;
                end
                repeat (div_s) @(negedge clk);
                sp = tx_s;
                rx_b.push_back(b);
                rx_ok.push_back(sb == 1'b0 && sp == 1'b1);
                rx_t.push_back(t0);
            end
        end
    end

    function automatic logic [31:0] rxb(input int i);
        if (i < rx_b.size()) return 32'(rx_b[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int rxt(input int i);
        if (i < rx_t.size()) return rx_t[i];
        return -1;
    endfunction

    function automatic logic [31:0] rxok(input int i);
        if (i < rx_ok.size()) return 32'(rx_ok[i]);
        return 32'd0;
    endfunction

    function automatic int rdc(input int i);
        if (i < rd_cyc.size()) return rd_cyc[i];
        return -1;
    endfunction

    function automatic int rda(input int i);
        if (i < rd_adr.size()) return rd_adr[i];
        return -1;
    endfunction

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [14:0] b, input logic [14:0] c, output int ts);
        base = b;
        cnt  = c;
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk);
        ts      = cyc;
        start_a = 1'b0;
        start_b = 1'b0;
        base    = ~b;
        cnt     = ~c;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_n >= target), 32'd1);
    endtask

    initial begin : main
        int          ts, m_rd, m_rx, m_dn, m_busy, m_txl, c;
        logic [14:0] b;
        logic [7:0]  e1 [4];
        e1[0] = 8'h78; e1[1] = 8'h56; e1[2] = 8'h34; e1[3] = 8'h12;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; base = '0; cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx",   32'(tx_a),    32'd1);
        chk("rst_busy", 32'(busy_a),  32'd0);
        chk("rst_done", 32'(done_a),  32'd0);
        chk("rst_rd",   32'(ifa.rd),  32'd0);
        chk("rst_adr",  32'(ifa.adr), 32'd0);
        chk("rst_tx_b", 32'(tx_b),    32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single word from dmem 0x4000
        m_rd = rd_adr.size(); m_rx = rx_b.size(); m_dn = done_n;
        kick(15'h4000, 15'd1, ts);
        chk("t1_busy_early", 32'(busy_a), 32'd1);
        wait_done(m_dn + 1, 400, "t1_done_seen");
        repeat (2) @(negedge clk);
        chk("t1_nrd",    32'(rd_adr.size() - m_rd), 32'd1);
        chk("t1_rd_adr", 32'(rda(m_rd)), 32'h4000);
        chk("t1_rd_cyc", 32'(rdc(m_rd) - ts), 32'd0);
        chk("t1_nbytes", 32'(rx_b.size() - m_rx), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_byte%0d", k),  rxb(m_rx + k), 32'(e1[k]));
            chk($sformatf("t1_frame%0d", k), rxok(m_rx + k), 32'd1);
            chk($sformatf("t1_time%0d", k),  32'(rxt(m_rx + k) - ts), 32'(2 + 40 * k));
        end
        chk("t1_done_cyc", 32'(done_cyc - ts), 32'd162);
        chk("t1_ndone",    32'(done_n - m_dn), 32'd1);
        chk("t1_busy_end", 32'(busy_a), 32'd0);

        // Three words wrapping 0x7FFF -> 0x0000
        m_rd = rd_adr.size(); m_rx = rx_b.size(); m_dn = done_n;
        kick(15'h7FFE, 15'd3, ts);
        wait_done(m_dn + 1, 700, "t2_done_seen");
        repeat (2) @(negedge clk);
        chk("t2_nrd",    32'(rd_adr.size() - m_rd), 32'd3);
        chk("t2_rd_a0",  32'(rda(m_rd)),     32'h7FFE);
        chk("t2_rd_a1",  32'(rda(m_rd + 1)), 32'h7FFF);
        chk("t2_rd_a2",  32'(rda(m_rd + 2)), 32'h0000);
        chk("t2_rd_c1",  32'(rdc(m_rd + 1) - ts), 32'd162);
        chk("t2_rd_c2",  32'(rdc(m_rd + 2) - ts), 32'd324);
        chk("t2_nbytes", 32'(rx_b.size() - m_rx), 32'd12);
        chk("t2_word0",  mem_word(15'h7FFE), 32'h3DFF_FEA5);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_byte%0d_%0d", w, k), rxb(m_rx + 4 * w + k),
                    32'(8'(mem_word(15'(15'h7FFE + w)) >> (8 * k))));
                chk($sformatf("t2_time%0d_%0d", w, k), 32'(rxt(m_rx + 4 * w + k) - ts),
                    32'(2 + 162 * w + 40 * k));
            end
        end
        chk("t2_done_cyc", 32'(done_cyc - ts), 32'd486);
        chk("t2_ndone",    32'(done_n - m_dn), 32'd1);

        // Zero-length dump
        m_rd = rd_adr.size(); m_dn = done_n; m_busy = busy_cnt; m_txl = txlow_cnt;
        kick(15'h1234, 15'd0, ts);
        wait_done(m_dn + 1, 10, "t3_done_seen");
        repeat (5) @(negedge clk);
        chk("t3_done_cyc", 32'(done_cyc - ts), 32'd0);
        chk("t3_ndone",    32'(done_n - m_dn), 32'd1);
        chk("t3_busy",     32'(busy_cnt - m_busy), 32'd0);
        chk("t3_txlow",    32'(txlow_cnt - m_txl), 32'd0);
        chk("t3_nrd",      32'(rd_adr.size() - m_rd), 32'd0);

        // Start pulses during byte 1 and during DONE are dropped
        m_rd = rd_adr.size(); m_rx = rx_b.size(); m_dn = done_n;
        kick(15'h4000, 15'd1, ts);
        while (cyc < ts + 55) @(negedge clk);
        start_a = 1'b1; base = 15'h0100; cnt = 15'd2;
        @(negedge clk);
        start_a = 1'b0;
        while (cyc < ts + 162) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (50) @(negedge clk);
        chk("t4_nrd",      32'(rd_adr.size() - m_rd), 32'd1);
        chk("t4_nbytes",   32'(rx_b.size() - m_rx), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t4_byte%0d", k), rxb(m_rx + k), 32'(e1[k]));
        chk("t4_done_cyc", 32'(done_cyc - ts), 32'd162);
        chk("t4_ndone",    32'(done_n - m_dn), 32'd1);

        // Reset during data bit 3 of byte 1 (0x56, bit 3 = 0)
        m_dn = done_n;
        kick(15'h4000, 15'd1, ts);
        while (cyc < ts + 59) @(negedge clk);
        chk("t5_tx_bit3", 32'(tx_a), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_tx_after",   32'(tx_a),   32'd1);
        chk("t5_busy_after", 32'(busy_a), 32'd0);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("t5_no_done", 32'(done_n - m_dn), 32'd0);
        m_rx = rx_b.size(); m_dn = done_n;
        kick(15'h0005, 15'd1, ts);
        wait_done(m_dn + 1, 400, "t5_done_seen");
        repeat (2) @(negedge clk);
        chk("t5_nbytes", 32'(rx_b.size() - m_rx), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_byte%0d", k),  rxb(m_rx + k), 32'(8'(mem_word(15'h0005) >> (8 * k))));
            chk($sformatf("t5_frame%0d", k), rxok(m_rx + k), 32'd1);
        end
        chk("t5_done_cyc", 32'(done_cyc - ts), 32'd162);

        // start held high: second dump begins on the first IDLE cycle after DONE
        m_rd = rd_adr.size(); m_dn = done_n;
        base = 15'h0010; cnt = 15'd1; start_a = 1'b1;
        @(negedge clk);
        ts = cyc;
        while (cyc < ts + 165) @(negedge clk);
        start_a = 1'b0;
        wait_done(m_dn + 2, 400, "t6_done_seen");
        repeat (2) @(negedge clk);
        chk("t6_nrd",    32'(rd_adr.size() - m_rd), 32'd2);
        chk("t6_rd_c1",  32'(rdc(m_rd + 1) - ts), 32'd164);
        chk("t6_ndone",  32'(done_n - m_dn), 32'd2);

        // Randomised dumps at the real baud divider
        use_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            b = 15'($urandom_range(0, 32767));
            c = (r == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 4));
            m_rd = rd_adr.size(); m_rx = rx_b.size(); m_dn = done_n;
            kick(b, 15'(c), ts);
            wait_done(m_dn + 1, c * 3600 + 100, $sformatf("r%0d_done_seen", r));
            repeat (2) @(negedge clk);
            chk($sformatf("r%0d_nrd", r),    32'(rd_adr.size() - m_rd), 32'(c));
            chk($sformatf("r%0d_nbytes", r), 32'(rx_b.size() - m_rx), 32'(4 * c));
            for (int w = 0; w < c; w++) begin
                chk($sformatf("r%0d_adr%0d", r, w), 32'(rda(m_rd + w)), 32'(15'(b + 15'(w))));
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("r%0d_byte%0d_%0d", r, w, k), rxb(m_rx + 4 * w + k),
                        32'(8'(mem_word(15'(b + 15'(w))) >> (8 * k))));
                    chk($sformatf("r%0d_frame%0d_%0d", r, w, k), rxok(m_rx + 4 * w + k), 32'd1);
                end
            end
            chk($sformatf("r%0d_ndone", r), 32'(done_n - m_dn), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_mem_dump.md
UART_MEM_DUMP -- requirements
Module: uart_mem_dump

Interface
REQ-001 Parameter CLK_DIV, default 87, meaning clock cycles per UART bit (10 MHz / 115200); legal range 2..65535.
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  dump request, sampled each cycle; acted on only in IDLE.
REQ-005 base_adr_i  input  15  first word address; bit 14 selects dmem (1) or imem (0); captured on the accepted start.
REQ-006 word_cnt_i  input  15  number of 32-bit words to send; captured on the accepted start.
REQ-007 mem_rd_o  output  1  one-cycle memory read strobe.
REQ-008 mem_adr_o  output  15  memory word address; valid while mem_rd_o=1.
REQ-009 mem_dat_i  input  32  read data; valid exactly one cycle after mem_rd_o.
REQ-010 tx_o  output  1  UART serial output, 8N1, idle high.
REQ-011 busy_o  output  1  high from the cycle after an accepted start until done_o.
REQ-012 done_o  output  1  one-cycle pulse at the end of the dump.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, CAPTURE, START, DATA, STOP and DONE.
REQ-014 IDLE: tx_o=1, busy_o=0; start_i=1 SHALL latch base/count and go to FETCH, or to DONE if word_cnt_i=0.
REQ-015 FETCH (1 cycle): mem_rd_o=1 and mem_adr_o=current address; next state CAPTURE.
REQ-016 CAPTURE (1 cycle): mem_dat_i SHALL be loaded into a 32-bit word register, byte index=0; next state START.
REQ-017 START: tx_o=0 for exactly CLK_DIV cycles; next state DATA.
REQ-018 DATA: 8 bits of the current byte SHALL be sent LSB first, each for exactly CLK_DIV cycles.
REQ-019 Byte order per word SHALL be [7:0], [15:8], [23:16], [31:24] (little-endian, matching the receiving programmer).
REQ-020 STOP: tx_o=1 for exactly CLK_DIV cycles.
REQ-021 After STOP, if byte index<3 the FSM SHALL increment the index and enter START with no idle gap.
REQ-022 After STOP of byte 3, the FSM SHALL decrement the remaining count. If it is nonzero, the address SHALL increment and the FSM SHALL go to FETCH, giving a 2-cycle idle-high gap. If it is zero, the FSM SHALL go to DONE.
REQ-023 DONE (1 cycle): done_o=1 and busy_o=0; next state IDLE.
REQ-024 Address increment SHALL be modulo 2^15 (0x7FFF+1 -> 0x0000).
REQ-025 Cycle timing for a start sampled at edge T SHALL be as follows:
- FETCH at T+1.
- CAPTURE at T+2.
- First start bit on tx_o from T+3.
- One word occupies 40*CLK_DIV cycles plus 2 cycles of fetch.
REQ-026 start_i while busy_o=1 or during DONE SHALL be ignored, with no queuing.
REQ-027 start_i held high continuously SHALL start a new dump on the first IDLE cycle after DONE.
REQ-028 The bit timer SHALL be a 16-bit down-counter reloaded with CLK_DIV-1 at each bit boundary; tx_o SHALL be driven from a register (glitch-free).
REQ-029 base_adr_i and word_cnt_i changes after acceptance SHALL have no effect on the current dump.

Reset
REQ-030 When reset=1 at an edge, the block SHALL set state=IDLE, tx_o=1, busy_o=0, done_o=0, mem_rd_o=0, mem_adr_o=0, and zero all counters.
REQ-031 Reset mid-frame SHALL force tx_o=1 on the next cycle, truncating the frame with no completion and no done_o.
REQ-032 Reset SHALL have priority over start_i in the same cycle.

Verification
REQ-033 CLK_DIV=4, base=0x4000, cnt=1, mem[0x4000]=0x12345678:
- Exactly one read, at 0x4000.
- tx bytes 0x78, 0x56, 0x34, 0x12.
- Each bit lasts 4 cycles.
- done_o at T+3+160.
REQ-034 CLK_DIV=4, cnt=3, base=0x7FFE:
- Reads at 0x7FFE, 0x7FFF, 0x0000.
- 12 bytes sent.
- 2-cycle high gaps between words only.
- A single done_o pulse.
REQ-035 cnt=0, start pulse -> done_o one cycle after start, busy_o never high, tx_o constantly 1, no mem_rd_o.
REQ-036 start_i pulsed again during the second byte -> ignored; byte stream and done timing identical to the single-start run.
REQ-037 reset asserted during DATA bit 3 of byte 1:
- tx_o=1 next cycle.
- busy_o=0, no done_o.
- A following start (cnt=1) produces a clean complete frame.
REQ-038 Scoreboard: a UART model samples tx_o mid-bit and checks start=0, stop=1 and the byte sequence against memory contents for random base/cnt (cnt ≤ 8) at CLK_DIV=87.
